// File: rtl/luma_pkg.sv
`default_nettype none
// ============================================================================
// luma_pkg : mode encodings, luma coefficients, rounding constant, RGB565 expand
// Rev 1.0
// ============================================================================
package luma_pkg;

  localparam logic [1:0] MODE_AVG   = 2'd0;
  localparam logic [1:0] MODE_BT601 = 2'd1;
  localparam logic [1:0] MODE_BT709 = 2'd2;
  localparam logic [1:0] MODE_GREEN = 2'd3;

  // 9-bit fields so the green-only weight of 256 fits
  typedef struct packed {
    logic [8:0] cr;
    logic [8:0] cg;
    logic [8:0] cb;
  } coef_t;

  localparam coef_t COEF_AVG   = '{cr: 9'd85, cg: 9'd86,  cb: 9'd85};
  localparam coef_t COEF_BT601 = '{cr: 9'd77, cg: 9'd150, cb: 9'd29};
  localparam coef_t COEF_BT709 = '{cr: 9'd54, cg: 9'd183, cb: 9'd19};
  localparam coef_t COEF_GREEN = '{cr: 9'd0,  cg: 9'd256, cb: 9'd0};

  localparam logic [16:0] ROUND_C = 17'd128;

  function automatic logic [23:0] expand_565(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic coef_t coef_for(input logic [1:0] m);
    coef_t c;
    case (m)
      MODE_AVG:   c = COEF_AVG;
      MODE_BT601: c = COEF_BT601;
      MODE_BT709: c = COEF_BT709;
      default:    c = COEF_GREEN;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/luma_lane.sv
`default_nettype none
// ============================================================================
// luma_lane : one pixel's datapath -- products in stage 1, rounded luma in stage 2
// Rev 1.0
// ============================================================================
module luma_lane
  import luma_pkg::*;
#(
  parameter  int IN_FMT = 0,
  localparam int PW     = (IN_FMT == 0) ? 16 : 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] pix,
  input  logic [1:0]    mode_sel,
  input  logic          load_s1,
  input  logic          load_s2,
  output logic [7:0]    luma
);

  logic [23:0] rgb;
  coef_t       coef;
  logic [16:0] prod_r_d, prod_g_d, prod_b_d;
  logic [16:0] prod_r_q, prod_g_q, prod_b_q;
  logic [18:0] sum;
  logic [10:0] scaled;
  logic [7:0]  luma_d, luma_q;

  generate
    if (IN_FMT == 0) begin : g_rgb565
      assign rgb = expand_565(pix);
    end else begin : g_rgb888
      assign rgb = pix;
    end
  endgenerate

  always_comb begin
    coef     = coef_for(mode_sel);
    prod_r_d = prod_r_q;
    prod_g_d = prod_g_q;
    prod_b_d = prod_b_q;
    if (load_s1) begin
      prod_r_d = 17'(rgb[23:16]) * 17'(coef.cr);
      prod_g_d = 17'(rgb[15:8])  * 17'(coef.cg);
      prod_b_d = 17'(rgb[7:0])   * 17'(coef.cb);
    end
    sum    = 19'(prod_r_q) + 19'(prod_g_q) + 19'(prod_b_q) + 19'(ROUND_C);
    scaled = 11'(sum >> 8);
    luma_d = luma_q;
    if (load_s2) begin
      luma_d = (scaled > 11'd255) ? 8'hFF : scaled[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      luma_q   <= '0;
    end else begin
      prod_r_q <= prod_r_d;
      prod_g_q <= prod_g_d;
      prod_b_q <= prod_b_d;
      luma_q   <= luma_d;
    end
  end

  assign luma = luma_q;

endmodule
`default_nettype wire

// File: rtl/color_to_luma_stream.sv
`default_nettype none
// ============================================================================
// color_to_luma_stream : streaming RGB565/RGB888 to 8-bit luma, 2-stage pipeline
// Rev 1.0
// ============================================================================
module color_to_luma_stream
  import luma_pkg::*;
#(
  parameter  int LANES  = 1,
  parameter  int IN_FMT = 0,
  localparam int PW     = (IN_FMT == 0) ? 16 : 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*PW-1:0] in_data,
  input  logic                in_sof,
  input  logic                in_eol,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*8-1:0]  out_data,
  output logic                out_sof,
  output logic                out_eol,
  output logic [15:0]         frame_pixels
);

  logic        v1_q, v1_d, v2_q, v2_d;
  logic        sof1_q, sof1_d, eol1_q, eol1_d;
  logic        sof2_q, sof2_d, eol2_q, eol2_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] frame_pixels_q, frame_pixels_d;
  logic [16:0] fp_sum;
  logic        s2_ready, s1_load, s2_load, out_fire;
  logic [1:0]  lane_mode;

  always_comb begin
    s2_ready  = !v2_q || out_ready;
    in_ready  = !v1_q || s2_ready;
    s1_load   = in_valid && in_ready;
    s2_load   = v1_q && s2_ready;
    out_fire  = v2_q && out_ready;
    // a start-of-frame beat is already processed with the newly requested mode
    lane_mode = in_sof ? mode : mode_q;

    v1_d   = s1_load || (v1_q && !s2_ready);
    v2_d   = s2_ready ? v1_q : v2_q;
    sof1_d = s1_load ? in_sof : sof1_q;
    eol1_d = s1_load ? in_eol : eol1_q;
    sof2_d = s2_load ? sof1_q : sof2_q;
    eol2_d = s2_load ? eol1_q : eol2_q;
    mode_d = (s1_load && in_sof) ? mode : mode_q;

    fp_sum         = {1'b0, frame_pixels_q} + 17'(LANES);
    frame_pixels_d = frame_pixels_q;
    if (out_fire) begin
      if (sof2_q) frame_pixels_d = 16'(LANES);
      else        frame_pixels_d = fp_sum[16] ? 16'hFFFF : fp_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      sof1_q         <= 1'b0;
      eol1_q         <= 1'b0;
      sof2_q         <= 1'b0;
      eol2_q         <= 1'b0;
      mode_q         <= MODE_BT601;
      frame_pixels_q <= '0;
    end else begin
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      sof1_q         <= sof1_d;
      eol1_q         <= eol1_d;
      sof2_q         <= sof2_d;
      eol2_q         <= eol2_d;
      mode_q         <= mode_d;
      frame_pixels_q <= frame_pixels_d;
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      luma_lane #(.IN_FMT(IN_FMT)) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix      (in_data[i*PW +: PW]),
        .mode_sel (lane_mode),
        .load_s1  (s1_load),
        .load_s2  (s2_load),
        .luma     (out_data[i*8 +: 8])
      );
    end
  endgenerate

  assign out_valid    = v2_q;
  assign out_sof      = sof2_q;
  assign out_eol      = eol2_q;
  assign frame_pixels = frame_pixels_q;

endmodule
`default_nettype wire

// File: tb/tb_color_to_luma_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_color_to_luma_stream : directed vectors on a 1-lane RGB565 and 2-lane RGB888 instance
// Rev 1.0
// ============================================================================
module tb_color_to_luma_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]  a_mode;
  logic        a_in_valid, a_in_ready, a_in_sof, a_in_eol;
  logic [15:0] a_in_data;
  logic        a_out_valid, a_out_ready, a_out_sof, a_out_eol;
  logic [7:0]  a_out_data;
  logic [15:0] a_fp;

  logic [1:0]  b_mode;
  logic        b_in_valid, b_in_ready, b_in_sof, b_in_eol;
  logic [47:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_sof, b_out_eol;
  logic [15:0] b_out_data;
  logic [15:0] b_fp;

  color_to_luma_stream #(.LANES(1), .IN_FMT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sof(a_in_sof), .in_eol(a_in_eol),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sof(a_out_sof), .out_eol(a_out_eol), .frame_pixels(a_fp)
  );

  color_to_luma_stream #(.LANES(2), .IN_FMT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sof(b_in_sof), .in_eol(b_in_eol),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sof(b_out_sof), .out_eol(b_out_eol), .frame_pixels(b_fp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Green-only stream pixel k: G6 value and its replicated 8-bit luma
  function automatic logic [5:0] stream_g6(input int k);
    return 6'((k * 5 + 3) % 64);
  endfunction

  function automatic logic [7:0] stream_luma(input int k);
    logic [5:0] g;
    g = stream_g6(k);
    return {g, g[5:4]};
  endfunction

  // One beat through DUT A with out_ready high; expects the result two cycles after acceptance
  task automatic a_beat(input string tag, input logic [15:0] d, input logic sof, input logic eol,
                        input logic [1:0] m, input logic [7:0] exp);
    a_in_data   = d;
    a_in_sof    = sof;
    a_in_eol    = eol;
    a_mode      = m;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    a_in_sof   = 1'b0;
    a_in_eol   = 1'b0;
    #1;
    check_eq({tag, "_lat1"}, 32'(a_out_valid), 32'd0);
    tick();
    check_eq({tag, "_vld"},  32'(a_out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(a_out_data),  32'(exp));
    check_eq({tag, "_sof"},  32'(a_out_sof),   32'(sof));
    check_eq({tag, "_eol"},  32'(a_out_eol),   32'(eol));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, emit, stale;
    logic seen_block;

    rst_n = 1'b0;
    a_mode = 2'd0; a_in_valid = 1'b0; a_in_data = '0; a_in_sof = 1'b0; a_in_eol = 1'b0;
    a_out_ready = 1'b1;
    b_mode = 2'd0; b_in_valid = 1'b0; b_in_data = '0; b_in_sof = 1'b0; b_in_eol = 1'b0;
    b_out_ready = 1'b1;
    repeat (3) tick();

    check_eq("rst_a_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_a_data",  32'(a_out_data),  32'd0);
    check_eq("rst_a_sof",   32'(a_out_sof),   32'd0);
    check_eq("rst_a_eol",   32'(a_out_eol),   32'd0);
    check_eq("rst_a_fp",    32'(a_fp),        32'd0);
    check_eq("rst_b_valid", 32'(b_out_valid), 32'd0);
    check_eq("rst_b_data",  32'(b_out_data),  32'd0);

    rst_n = 1'b1;
    #1;
    check_eq("rel_a_rdy", 32'(a_in_ready), 32'd1);
    check_eq("rel_b_rdy", 32'(b_in_ready), 32'd1);
    tick();

    // reset mode is BT.601; a non-sof beat requesting mode 0 must not change it
    a_beat("init_mode", 16'hF800, 1'b0, 1'b0, 2'd0, 8'h4D);
    a_beat("bt601_white", 16'hFFFF, 1'b1, 1'b0, 2'd1, 8'hFF);
    a_beat("bt601_red",   16'hF800, 1'b0, 1'b0, 2'd1, 8'h4D);
    tick();
    check_eq("fp_after_601", 32'(a_fp), 32'd2);

    a_beat("bt709_red",   16'hF800, 1'b1, 1'b0, 2'd2, 8'h36);
    a_beat("bt709_keep",  16'h001F, 1'b0, 1'b0, 2'd0, 8'h13);
    a_beat("avg_blue",    16'h001F, 1'b1, 1'b0, 2'd0, 8'h55);
    a_beat("green_only",  16'h07E0, 1'b1, 1'b1, 2'd3, 8'hFF);
    tick();
    check_eq("fp_after_sof", 32'(a_fp), 32'd1);

    // 20-beat stream, output stalled on cycles 5..9
    acc = 0; emit = 0; seen_block = 1'b0;
    a_mode = 2'd3;
    for (int cyc = 0; cyc < 80 && emit < 20; cyc++) begin
      a_out_ready = !(cyc >= 5 && cyc <= 9);
      a_in_valid  = (acc < 20);
      a_in_data   = {5'd0, stream_g6(acc), 5'd0};
      a_in_sof    = (acc == 0);
      a_in_eol    = (acc == 19);
      #1;
      if (a_out_valid) check_eq("stream_data", 32'(a_out_data), 32'(stream_luma(emit)));
      if (!a_in_ready && !seen_block) begin
        seen_block = 1'b1;
        check_eq("stream_held", 32'(acc - emit), 32'd2);
      end
      if (a_out_valid && a_out_ready) emit++;
      if (a_in_valid && a_in_ready) acc++;
      tick();
    end
    a_in_valid = 1'b0;
    a_in_sof   = 1'b0;
    a_in_eol   = 1'b0;
    a_out_ready = 1'b1;
    check_eq("stream_count",   32'(emit), 32'd20);
    check_eq("stream_blocked", 32'(seen_block), 32'd1);
    check_eq("stream_fp",      32'(a_fp), 32'd20);
    tick();

    // fill both stages, then reset with the beats still in flight
    a_out_ready = 1'b0;
    a_in_data   = 16'hFFFF;
    a_in_valid  = 1'b1;
    tick();
    tick();
    a_in_valid = 1'b0;
    #1;
    check_eq("inflight_vld", 32'(a_out_valid), 32'd1);
    check_eq("inflight_rdy", 32'(a_in_ready),  32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_vld",  32'(a_out_valid), 32'd0);
    check_eq("midrst_fp",   32'(a_fp),        32'd0);
    check_eq("midrst_data", 32'(a_out_data),  32'd0);
    tick();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    stale = 0;
    repeat (4) begin
      tick();
      if (a_out_valid) stale++;
    end
    check_eq("midrst_stale", 32'(stale), 32'd0);
    a_beat("midrst_mode", 16'hF800, 1'b0, 1'b0, 2'd0, 8'h4D);
    tick();

    // two-lane RGB888 instance
    b_mode = 2'd1; b_in_data = {24'h000000, 24'hFFFFFF}; b_in_sof = 1'b1; b_in_eol = 1'b0;
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    check_eq("b1_rdy", 32'(b_in_ready), 32'd1);
    tick();
    b_in_valid = 1'b0;
    b_in_sof   = 1'b0;
    tick();
    check_eq("b1_vld",  32'(b_out_valid), 32'd1);
    check_eq("b1_data", 32'(b_out_data),  32'h00FF);
    check_eq("b1_sof",  32'(b_out_sof),   32'd1);
    b_in_data  = {24'hFFFFFF, 24'h000000};
    b_in_eol   = 1'b1;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    b_in_eol   = 1'b0;
    check_eq("b1_fp", 32'(b_fp), 32'd2);
    tick();
    check_eq("b2_vld",  32'(b_out_valid), 32'd1);
    check_eq("b2_data", 32'(b_out_data),  32'hFF00);
    check_eq("b2_eol",  32'(b_out_eol),   32'd1);
    check_eq("b2_sof",  32'(b_out_sof),   32'd0);
    tick();
    check_eq("b2_fp", 32'(b_fp), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
